// File: rtl/stage1_fetch.sv
// Fetch stage: owns the PC, issues in-order word reads to instruction memory,
// buffers returned instructions in a small FIFO and presents them to decode.
module stage1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        do_flush,
  input  logic [31:0] s1a_instruction_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        s2_valid,
  output logic [31:0] s2_instruction,
  output logic [31:0] s2_instruction_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;

  typedef logic [CW-1:0] cnt_t;

  logic [31:0]   pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_addr  [DEPTH];
  logic [31:0]   tag_addr   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] tag_wr;
  cnt_t          count;
  cnt_t          inflight;
  cnt_t          drop;
  cnt_t          live;
  cnt_t          credit;
  logic          fire;
  logic          keep;
  logic          pop;
  logic          unused_low;

  assign unused_low = ^s1a_instruction_addr[1:0];

  assign live   = inflight - drop;
  assign credit = live + count;

  assign imem_req_valid = !reset && !do_flush &&
                          (credit < cnt_t'(DEPTH));
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign keep = imem_resp_valid && !do_flush && (drop == '0);

  assign s2_valid            = (count != '0) && !do_flush;
  assign pop                 = s2_valid && !stall;
  assign s2_instruction      = fifo_instr[head];
  assign s2_instruction_addr = fifo_addr[head];

  // Tag queue holds only live requests, so a redirect simply empties it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (do_flush) begin
      pc       <= {s1a_instruction_addr[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      inflight <= inflight - cnt_t'(imem_resp_valid);
      drop     <= inflight - cnt_t'(imem_resp_valid);
    end else begin
      if (fire) begin
        pc     <= pc + 32'd4;
        tag_wr <= tag_wr + 1'b1;
      end
      if (keep) begin
        tail   <= tail + 1'b1;
        tag_rd <= tag_rd + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count    <= count + cnt_t'(keep) - cnt_t'(pop);
      inflight <= inflight + cnt_t'(fire) - cnt_t'(imem_resp_valid);
      if (imem_resp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (fire) tag_addr[tag_wr] <= pc;
    if (keep) begin
      fifo_instr[tail] <= imem_resp_data;
      fifo_addr[tail]  <= tag_addr[tag_rd];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && keep) assert (count < cnt_t'(DEPTH));
  end

endmodule
